count_event_fifo: RTL and testbench
===================================

// Module: count_event_fifo
// PURPOSE
//  Downstream consumer of the 8-bit free-running counter value. Watches the count every clock.
//  Detects wrap (MAX->0) and restart (any other drop to 0) events, plus an external capture strobe.
//  Logs each event as a tagged record in a small FIFO. Records drain over a valid/ready port
//  to the monitor/logging stage.
// PARAMETERS
//  WIDTH   8   counter value width; MAX = 2**WIDTH-1
//  DEPTH   4   FIFO entries; power of 2, >=2
//  AW      2   log2(DEPTH); must match DEPTH
// PORTS
//  clock      in   1         rising-edge clock, same domain as counter
//  reset_n    in   1         asynchronous, active-low reset
//  value      in   WIDTH     counter output, sampled every rising edge
//  capture    in   1         one-cycle strobe: log current value
//  out_ready  in   1         consumer accepts head record this cycle
//  clear_ovf  in   1         clears overflow and drop_cnt
//  out_valid  out  1         head record valid
//  out_data   out  WIDTH+3   {cap, restart, wrap, value}
//  level      out  AW+1      entries held, 0..DEPTH
//  overflow   out  1         sticky: a record was dropped
//  drop_cnt   out  8         records dropped, saturates at 255
// BEHAVIOUR
//  Reset: async on reset_n low. FIFO empty, pointers 0, out_valid=0, out_data=0, level=0.
//   Also overflow=0, drop_cnt=0, prev=0, prev_ok=0. Output changes only on clock after release.
//  prev register: prev<=value every edge; prev_ok<=1 from first edge after reset.
//  Event decode (combinational on value, prev; only when prev_ok=1):
//   wrap    = prev==MAX && value==0
//   restart = value==0 && prev!=0 && prev!=MAX
//   cap     = capture
//  push = wrap|restart|cap. One record per cycle, all set flags ORed into it.
//   Tagged value = current value.
//  pop = out_valid && out_ready.
//  Accept rule: push written if level<DEPTH, or if level==DEPTH and pop this cycle.
//   Simultaneous push+pop on full: pop head, write tail, level unchanged.
//  Drop: push while full and no pop. Record discarded, overflow<=1, drop_cnt+1 (sat 255).
//  clear_ovf: overflow<=0, drop_cnt<=0. If a drop happens in the same cycle:
//   overflow=1, drop_cnt=1 (drop wins).
//  Pop on empty: impossible by definition (out_valid=0). out_ready is ignored while empty.
//  Pointers are AW-bit and wrap modulo DEPTH. level is a separate AW+1-bit counter:
//   +1 on accepted push without pop; -1 on pop without push.
//  Output is first-word-fall-through, registered:
//   out_data = mem[rd_ptr]; out_valid = (level!=0).
//   Record pushed at edge N into an empty FIFO has out_valid=1 after edge N (1-cycle latency).
//   Push into empty with no pop is never lost, even when out_ready is held high.
//  out_data holds its value while out_valid=0. It is not cleared on pop.
//  Counter held at 0 (reset held high upstream) produces no repeat events.
//   A value==prev condition never decodes as an event.
//  No internal state machine beyond FIFO/prev. Event decode uses no throttle or holdoff.
// TESTING
//  T1 reset: reset_n=0 mid-stream with 3 records held -> level=0, out_valid=0, overflow=0
//   immediately (async). The first edge after release logs no event even if value==0.
//  T2 wrap: drive value 254,255,0,1 with out_ready=0 -> exactly one record.
//   out_data={0,0,1,8'h00}, level=1.
//  T3 restart: counter at 8'h1C, pulse counter reset -> value 0. Record {0,1,0,8'h00}.
//   Holding reset 5 more cycles adds no records.
//  T4 coincident: capture=1 on the cycle value goes 255->0 -> single record {1,0,1,8'h00}.
//  T5 overflow: out_ready=0, 6 capture strobes at values 10..15 -> level=4, overflow=1,
//   drop_cnt=2. Drain yields 10,11,12,13 in order. clear_ovf -> overflow=0, drop_cnt=0.
//  T6 full push+pop: FIFO full, capture and out_ready=1 same cycle -> level stays 4,
//   drop_cnt unchanged. New value appears as the 4th record drained.

Source files
------------

// File: rtl/count_event_fifo.sv
// Logs counter wrap/restart/capture events as tagged records; FWFT out, 1-cycle push-to-valid latency.
// Backpressure via out_ready; pushes into a full FIFO without a pop are dropped and counted.
module count_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] value,
  input  logic             capture,
  input  logic             out_ready,
  input  logic             clear_ovf,
  output logic             out_valid,
  output logic [WIDTH+2:0] out_data,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [7:0]       drop_cnt
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [AW:0]      FULL = (AW+1)'(DEPTH);

  logic [WIDTH+2:0] mem_q [DEPTH];
  logic [WIDTH+2:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_ok_q, prev_ok_d;

  logic wrap, restart, cap, push, pop, full, accept, drop;

  always_comb begin
    wrap    = prev_ok_q && (prev_q == MAX) && (value == '0);
    restart = prev_ok_q && (value == '0) && (prev_q != '0) && (prev_q != MAX);
    cap     = prev_ok_q && capture;
    push    = wrap || restart || cap;
    pop     = (level_q != '0) && out_ready;
    full    = (level_q == FULL);
    // On full, a same-cycle pop frees the head slot, which is exactly where the tail points.
    accept  = push && (!full || pop);
    drop    = push && full && !pop;

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    prev_d     = value;
    prev_ok_d  = 1'b1;

    if (accept) begin
      mem_d[wr_ptr_q] = {cap, restart, wrap, value};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (accept && !pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (pop && !accept) begin
      level_d = level_q - (AW+1)'(1);
    end

    // A drop in the clearing cycle still registers as the first new drop.
    if (clear_ovf) begin
      overflow_d = drop;
      drop_cnt_d = drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      prev_q     <= prev_d;
      prev_ok_q  <= prev_ok_d;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_count_event_fifo.sv
// Scoreboarded bench for count_event_fifo: expected records queued at stimulus, checked on each handshake.
module tb_count_event_fifo;

  logic        clock;
  logic        reset_n;
  logic [7:0]  value;
  logic        capture;
  logic        out_ready;
  logic        clear_ovf;
  logic        out_valid;
  logic [10:0] out_data;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks;
  int failures;
  logic [10:0] exp_q[$];

  count_event_fifo #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .value     (value),
    .capture   (capture),
    .out_ready (out_ready),
    .clear_ovf (clear_ovf),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  // Each negedge with valid&ready is one pop at the following posedge.
  task automatic monitor();
    logic [10:0] exp;
    forever begin
      @(negedge clock);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_record: got %0h expected none", out_data);
        end else begin
          exp = exp_q.pop_front();
          check("record", {21'd0, out_data}, {21'd0, exp});
        end
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    value     = 8'd0;
    capture   = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;

    fork
      monitor();
    join_none

    #2;
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {21'd0, out_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("idle_zero_level", {29'd0, level}, 32'd0);

    // wrap 255->0 with consumer stalled
    value = 8'd254; tick();
    value = 8'd255; tick();
    value = 8'd0; exp_q.push_back(11'h100); tick();
    value = 8'd1; tick();
    check("wrap_level", {29'd0, level}, 32'd1);
    check("wrap_valid", {31'd0, out_valid}, 32'd1);
    check("wrap_data", {21'd0, out_data}, 32'h100);
    drain(1);
    check("wrap_drained", {29'd0, level}, 32'd0);

    // restart from 0x1C, then hold at zero
    value = 8'h1C; tick();
    value = 8'd0; exp_q.push_back(11'h200); tick();
    repeat (5) tick();
    check("restart_level", {29'd0, level}, 32'd1);
    drain(1);
    check("restart_drained", {29'd0, level}, 32'd0);

    // capture coincident with wrap
    value = 8'd254; tick();
    value = 8'd255; tick();
    value = 8'd0; capture = 1'b1; exp_q.push_back(11'h500); tick();
    capture = 1'b0;
    check("coinc_level", {29'd0, level}, 32'd1);
    drain(1);

    // overflow: six captures into four slots
    for (int v = 10; v <= 15; v++) begin
      value = 8'(v);
      capture = 1'b1;
      if (v <= 13) exp_q.push_back({3'b100, 8'(v)});
      tick();
    end
    capture = 1'b0;
    check("ovf_level", {29'd0, level}, 32'd4);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_drop", {24'd0, drop_cnt}, 32'd2);
    drain(4);
    check("ovf_drained", {29'd0, level}, 32'd0);
    clear_ovf = 1'b1; tick();
    clear_ovf = 1'b0;
    check("clr_flag", {31'd0, overflow}, 32'd0);
    check("clr_drop", {24'd0, drop_cnt}, 32'd0);

    // fill, drop coincident with clear, then push+pop on full
    for (int v = 20; v <= 23; v++) begin
      value = 8'(v);
      capture = 1'b1;
      exp_q.push_back({3'b100, 8'(v)});
      tick();
    end
    value = 8'd24; clear_ovf = 1'b1; tick();
    clear_ovf = 1'b0;
    check("clrdrop_flag", {31'd0, overflow}, 32'd1);
    check("clrdrop_cnt", {24'd0, drop_cnt}, 32'd1);
    value = 8'd25; out_ready = 1'b1; exp_q.push_back(11'h419); tick();
    capture = 1'b0;
    check("pp_level", {29'd0, level}, 32'd4);
    check("pp_drop", {24'd0, drop_cnt}, 32'd1);
    drain(4);
    check("pp_drained", {29'd0, level}, 32'd0);

    // async reset with 3 records held
    for (int v = 30; v <= 32; v++) begin
      value = 8'(v);
      capture = 1'b1;
      exp_q.push_back({3'b100, 8'(v)});
      tick();
    end
    capture = 1'b0;
    check("pre_rst_level", {29'd0, level}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_level", {29'd0, level}, 32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_ovf", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    value = 8'd0;
    capture = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    capture = 1'b0;
    check("first_edge_level", {29'd0, level}, 32'd0);
    check("first_edge_valid", {31'd0, out_valid}, 32'd0);
    capture = 1'b1; exp_q.push_back(11'h400); tick();
    capture = 1'b0;
    check("post_rst_level", {29'd0, level}, 32'd1);
    drain(1);

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
